// File: rtl/adder_tree_pkg.sv
// Shared types and helpers for the adder_tree_acc reduction pipeline.
// The saturating variant is selected with ADDER_TREE_ACC_SAT_EN in the top.
package adder_tree_pkg;

    localparam int DEFAULT_N     = 16;
    localparam int DEFAULT_IN_W  = 8;
    localparam int DEFAULT_ACC_W = 32;

    typedef struct packed {
        logic valid;
        logic last;
    } sideband_t;

    // Lane count rounded up to the next power of two; extra lanes are tied to zero.
    function automatic int padLanes(input int n);
        return 1 << $clog2(n);
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered reduction level of the adder tree: adds adjacent lane pairs
// one bit wider than the inputs and carries the valid/last sideband alongside.
module adder_tree_level
    import adder_tree_pkg::*;
#(
    parameter int IN_W_L = 8,
    parameter int PAIRS  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic signed [IN_W_L-1:0] data_i [2*PAIRS],
    input  sideband_t                sb_i,
    output logic signed [IN_W_L:0]   sum_o  [PAIRS],
    output sideband_t                sb_o
);

    logic signed [IN_W_L:0] sum_d [PAIRS];
    logic signed [IN_W_L:0] sum_q [PAIRS];
    sideband_t              sb_q;

    always_comb begin
        for (int p = 0; p < PAIRS; p++) begin
            sum_d[p] = (IN_W_L+1)'(data_i[2*p]) + (IN_W_L+1)'(data_i[2*p+1]);
        end
    end

    // The whole level freezes with the global stall enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sb_q <= '0;
            for (int p = 0; p < PAIRS; p++) begin
                sum_q[p] <= '0;
            end
        end else if (en) begin
            sb_q <= sb_i;
            for (int p = 0; p < PAIRS; p++) begin
                sum_q[p] <= sum_d[p];
            end
        end
    end

    assign sum_o = sum_q;
    assign sb_o  = sb_q;

endmodule

// File: rtl/adder_tree_acc.sv
// Pipelined signed adder tree with valid/ready handshake and multi-beat accumulation.
// Define ADDER_TREE_ACC_SAT_EN for a saturating accumulator and the out_sat flag.
module adder_tree_acc
    import adder_tree_pkg::*;
#(
    parameter int N      = DEFAULT_N,
    parameter int IN_W   = DEFAULT_IN_W,
    parameter int ACC_W  = DEFAULT_ACC_W,
    parameter int LEVELS = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_data [N-1:0],
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_data
`ifdef ADDER_TREE_ACC_SAT_EN
    ,
    output logic                    out_sat
`endif
);

    localparam int NP = padLanes(N);
    localparam int TW = IN_W + LEVELS;

    logic                    en;
    logic signed [IN_W-1:0]  lanes [NP];
    sideband_t               sbIn;
    logic signed [TW-1:0]    treeData;
    sideband_t               treeSb;
    logic signed [ACC_W-1:0] treeExt;
    logic signed [ACC_W-1:0] sumVal;

    logic signed [ACC_W-1:0] acc_d, acc_q;
    logic signed [ACC_W-1:0] outData_d, outData_q;
    logic                    outValid_d, outValid_q;

    // Single stall enable: everything moves unless a result is stuck at the output.
    assign en       = !outValid_q || out_ready;
    assign in_ready = en;
    assign sbIn     = '{valid: in_valid, last: in_last};

    for (genvar i = 0; i < NP; i++) begin : g_lane
        if (i < N) begin : g_real
            assign lanes[i] = in_data[i];
        end else begin : g_pad
            assign lanes[i] = '0;
        end
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int PAIRS = NP >> k;
        logic signed [IN_W+k-1:0] sum [PAIRS];
        sideband_t                sb;

        if (k == 1) begin : g_src
            adder_tree_level #(
                .IN_W_L(IN_W),
                .PAIRS (PAIRS)
            ) u_level (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (en),
                .data_i(lanes),
                .sb_i  (sbIn),
                .sum_o (sum),
                .sb_o  (sb)
            );
        end else begin : g_src
            adder_tree_level #(
                .IN_W_L(IN_W + k - 1),
                .PAIRS (PAIRS)
            ) u_level (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (en),
                .data_i(g_lvl[k-1].sum),
                .sb_i  (g_lvl[k-1].sb),
                .sum_o (sum),
                .sb_o  (sb)
            );
        end
    end

    // With a single lane there is no tree and the accumulator sees the input directly.
    if (LEVELS == 0) begin : g_flat
        assign treeData = lanes[0];
        assign treeSb   = sbIn;
    end else begin : g_tree
        assign treeData = g_lvl[LEVELS].sum[0];
        assign treeSb   = g_lvl[LEVELS].sb;
    end

    assign treeExt = ACC_W'(treeData);

`ifdef ADDER_TREE_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = ~ACC_MAX;

    logic signed [ACC_W:0] wideSum;
    logic                  clamp;
    logic                  satSticky_d, satSticky_q;
    logic                  outSat_d, outSat_q;

    assign wideSum = (ACC_W+1)'(treeExt) + (ACC_W+1)'(acc_q);
    assign clamp   = wideSum[ACC_W] ^ wideSum[ACC_W-1];
    assign sumVal  = !clamp ? wideSum[ACC_W-1:0] : (wideSum[ACC_W] ? ACC_MIN : ACC_MAX);
`else
    assign sumVal  = treeExt + acc_q;
`endif

    always_comb begin
        acc_d      = acc_q;
        outData_d  = outData_q;
        outValid_d = outValid_q;
`ifdef ADDER_TREE_ACC_SAT_EN
        satSticky_d = satSticky_q;
        outSat_d    = outSat_q;
`endif
        if (en) begin
            outValid_d = 1'b0;
            if (treeSb.valid) begin
                if (treeSb.last) begin
                    outData_d  = sumVal;
                    outValid_d = 1'b1;
                    acc_d      = '0;
`ifdef ADDER_TREE_ACC_SAT_EN
                    outSat_d    = satSticky_q | clamp;
                    satSticky_d = 1'b0;
`endif
                end else begin
                    acc_d = sumVal;
`ifdef ADDER_TREE_ACC_SAT_EN
                    satSticky_d = satSticky_q | clamp;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q      <= '0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            outData_q  <= outData_d;
            outValid_q <= outValid_d;
        end
    end

`ifdef ADDER_TREE_ACC_SAT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            satSticky_q <= 1'b0;
            outSat_q    <= 1'b0;
        end else begin
            satSticky_q <= satSticky_d;
            outSat_q    <= outSat_d;
        end
    end

    assign out_sat = outSat_q;
`endif

    assign out_valid = outValid_q;
    assign out_data  = outData_q;

endmodule

// File: tb/tb_adder_tree_acc.sv
// Directed bench for adder_tree_acc: a N=4/ACC_W=16 instance for the main scenarios
// plus N=3 and N=4 instances at ACC_W=12 for the width/wrap/saturation cases.
module tb_adder_tree_acc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   cycleCount = 0;
    int   stallSeen = 0;

    logic               inValid, inReady, inLast;
    logic signed [7:0]  inData [3:0];
    logic               outValid, outReady;
    logic signed [15:0] outData;

    logic               nValid, nLast, nOutReady;
    logic signed [7:0]  n3Data [2:0];
    logic signed [7:0]  n4Data [3:0];
    logic               n3Ready, n4Ready, n3OutValid, n4OutValid;
    logic signed [11:0] n3OutData, n4OutData;

`ifdef ADDER_TREE_ACC_SAT_EN
    logic outSat, n3Sat, n4Sat;
`endif

    adder_tree_acc #(.N(4), .IN_W(8), .ACC_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValid), .in_ready(inReady), .in_data(inData), .in_last(inLast),
        .out_valid(outValid), .out_ready(outReady), .out_data(outData)
`ifdef ADDER_TREE_ACC_SAT_EN
        , .out_sat(outSat)
`endif
    );

    adder_tree_acc #(.N(3), .IN_W(8), .ACC_W(12)) dutN3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(nValid), .in_ready(n3Ready), .in_data(n3Data), .in_last(nLast),
        .out_valid(n3OutValid), .out_ready(nOutReady), .out_data(n3OutData)
`ifdef ADDER_TREE_ACC_SAT_EN
        , .out_sat(n3Sat)
`endif
    );

    adder_tree_acc #(.N(4), .IN_W(8), .ACC_W(12)) dutN4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(nValid), .in_ready(n4Ready), .in_data(n4Data), .in_last(nLast),
        .out_valid(n4OutValid), .out_ready(nOutReady), .out_data(n4OutData)
`ifdef ADDER_TREE_ACC_SAT_EN
        , .out_sat(n4Sat)
`endif
    );

    always @(posedge clk) cycleCount++;

    // Every completed output handshake is logged with the cycle it happened in.
    logic signed [15:0] gotQ [$];
    int                 cycQ [$];
    always @(negedge clk) begin
        if (rst_n && outValid && outReady) begin
            gotQ.push_back(outData);
            cycQ.push_back(cycleCount);
        end
    end

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint gotAt(input int i);
        return (gotQ.size() > i) ? longint'(gotQ[i]) : -99999;
    endfunction

    function automatic longint cycAt(input int i);
        return (cycQ.size() > i) ? longint'(cycQ[i]) : -99999;
    endfunction

    task automatic clearResults();
        gotQ.delete();
        cycQ.delete();
    endtask

    task automatic applyStimulus(input int l0, input int l1, input int l2, input int l3, input logic last);
        int guard;
        guard = 0;
        inData[0] = l0[7:0];
        inData[1] = l1[7:0];
        inData[2] = l2[7:0];
        inData[3] = l3[7:0];
        inLast  = last;
        inValid = 1'b1;
        #1;
        while (!inReady && guard < 40) begin
            @(posedge clk);
            #2;
            guard++;
            stallSeen++;
        end
        if (!inReady) checkOutput("in_ready wait", inReady, 1);
        tick();
        inValid = 1'b0;
        inLast  = 1'b0;
    endtask

    task automatic waitResults(input int n, input string tag);
        int guard;
        guard = 0;
        while (gotQ.size() < n && guard < 60) begin
            tick();
            guard++;
        end
        if (gotQ.size() < n) checkOutput({tag, " result wait"}, gotQ.size(), n);
        repeat (4) tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        longint res3, res4, sat3, sat4;
        int     cnt3, cnt4;

        rst_n = 1'b0;
        inValid = 1'b0; inLast = 1'b0; outReady = 1'b1;
        nValid = 1'b0; nLast = 1'b0; nOutReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inData[i] = '0;
            n4Data[i] = '0;
        end
        for (int i = 0; i < 3; i++) n3Data[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        checkOutput("reset out_valid", outValid, 0);
        checkOutput("reset in_ready", inReady, 1);
        checkOutput("reset out_data", outData, 0);

        // Single-beat dot product: valid appears in the third cycle after acceptance, for one cycle.
        applyStimulus(1, 2, 3, 4, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checkOutput($sformatf("t1 valid c%0d", c), outValid, (c == 3) ? 1 : 0);
            if (c == 3) checkOutput("t1 data", outData, 10);
        end
        tick();
        checkOutput("t1 count", gotQ.size(), 1);
        clearResults();

        applyStimulus(-128, -128, -128, -128, 1'b0);
        applyStimulus(-128, -128, -128, -128, 1'b0);
        applyStimulus(127, 127, 127, 127, 1'b1);
        waitResults(1, "t2");
        checkOutput("t2 count", gotQ.size(), 1);
        checkOutput("t2 data", gotAt(0), -516);
`ifdef ADDER_TREE_ACC_SAT_EN
        checkOutput("t2 sat", outSat, 0);
`endif
        clearResults();

        stallSeen = 0;
        applyStimulus(1, 2, 3, 4, 1'b1);
        applyStimulus(5, 6, 7, 8, 1'b1);
        checkOutput("t3 in_ready stalls", stallSeen, 0);
        waitResults(2, "t3");
        checkOutput("t3 count", gotQ.size(), 2);
        checkOutput("t3 first", gotAt(0), 10);
        checkOutput("t3 second", gotAt(1), 26);
        checkOutput("t3 spacing", cycAt(1) - cycAt(0), 1);
        clearResults();

        // Three results queue up behind a blocked output, then drain in order.
        outReady = 1'b0;
        applyStimulus(1, 1, 1, 1, 1'b1);
        applyStimulus(2, 2, 2, 2, 1'b1);
        applyStimulus(3, 3, 3, 3, 1'b1);
        for (int s = 1; s <= 5; s++) begin
            @(negedge clk);
            checkOutput($sformatf("t4 in_ready s%0d", s), inReady, 0);
            checkOutput($sformatf("t4 hold data s%0d", s), outData, 4);
            checkOutput($sformatf("t4 hold valid s%0d", s), outValid, 1);
        end
        tick();
        outReady = 1'b1;
        applyStimulus(4, 4, 4, 4, 1'b1);
        waitResults(4, "t4");
        checkOutput("t4 count", gotQ.size(), 4);
        for (int r = 0; r < 4; r++) begin
            checkOutput($sformatf("t4 order %0d", r), gotAt(r), 4 * (r + 1));
        end
        clearResults();

        applyStimulus(9, 9, 9, 9, 1'b0);
        applyStimulus(9, 9, 9, 9, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("t5 out_valid after reset", outValid, 0);
        checkOutput("t5 in_ready after reset", inReady, 1);
        applyStimulus(1, 1, 1, 1, 1'b1);
        waitResults(1, "t5");
        checkOutput("t5 count", gotQ.size(), 1);
        checkOutput("t5 data", gotAt(0), 4);
        clearResults();

        checkOutput("t6 n3 ready", n3Ready, 1);
        checkOutput("t6 n4 ready", n4Ready, 1);
        for (int i = 0; i < 3; i++) n3Data[i] = 8'sd127;
        for (int i = 0; i < 4; i++) n4Data[i] = 8'sd127;
        nValid = 1'b1;
        for (int b = 0; b < 5; b++) begin
            nLast = (b == 4);
            tick();
        end
        nValid = 1'b0;
        nLast  = 1'b0;
        cnt3 = 0; cnt4 = 0; res3 = 0; res4 = 0; sat3 = 0; sat4 = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (n3OutValid) begin
                cnt3++;
                res3 = n3OutData;
`ifdef ADDER_TREE_ACC_SAT_EN
                sat3 = n3Sat;
`endif
            end
            if (n4OutValid) begin
                cnt4++;
                res4 = n4OutData;
`ifdef ADDER_TREE_ACC_SAT_EN
                sat4 = n4Sat;
`endif
            end
        end
        checkOutput("t6 n3 count", cnt3, 1);
        checkOutput("t6 n3 data", res3, 1905);
        checkOutput("t6 n4 count", cnt4, 1);
`ifdef ADDER_TREE_ACC_SAT_EN
        checkOutput("t6 n4 data", res4, 2047);
        checkOutput("t6 n4 sat", sat4, 1);
        checkOutput("t6 n3 sat", sat3, 0);
`else
        checkOutput("t6 n4 data", res4, -1556);
        checkOutput("t6 sat flags", sat3 + sat4, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
